// File: rtl/riscv_lsu.sv
// Load-store unit: turns an ALU effective address into one data-memory
// transaction per core request. Generates byte enables, replicates store
// data, extracts and extends load data, flags misaligned or illegal
// accesses without touching the bus, and aborts a bus access that never
// completes. The core is stalled until the response cycle.
//
// Handshake: the core raises core_req_i and holds all core_* inputs stable
// while core_stall_o=1; the single cycle with core_req_i=1 and
// core_stall_o=0 is the response. On the memory side mem_req_o stays high
// with stable we/be/addr/wd until mem_ready_i=1 is sampled on a rising
// edge; mem_ready_i is ignored whenever mem_req_o=0.
module riscv_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic [1:0]  dbg_state_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [2:0]    size_q;
  logic [1:0]    off_q;
  logic [29:0]   waddr_q;
  logic [3:0]    be_q;
  logic [31:0]   wd_q;
  logic [31:0]   rd_q;
  logic          fault_q;
  logic          berr_q;

  logic          dec_fault;
  logic [3:0]    dec_be;
  logic [31:0]   dec_wd;
  logic [31:0]   ext_rd;
  logic          timeout;

  // Decode the incoming request: legality, alignment, byte enables and lane data.
  always_comb begin
    dec_fault = 1'b0;
    dec_be    = 4'b1111;
    dec_wd    = core_wd_i;
    case (core_size_i)
      3'd0, 3'd4: dec_fault = 1'b0;
      3'd1, 3'd5: dec_fault = core_addr_i[0];
      3'd2:       dec_fault = (core_addr_i[1:0] != 2'b00);
      default:    dec_fault = 1'b1;
    endcase
    case (core_size_i[1:0])
      2'd0: begin
        dec_be = 4'b0001 << core_addr_i[1:0];
        dec_wd = {4{core_wd_i[7:0]}};
      end
      2'd1: begin
        dec_be = core_addr_i[1] ? 4'b1100 : 4'b0011;
        dec_wd = {2{core_wd_i[15:0]}};
      end
      default: begin
        dec_be = 4'b1111;
        dec_wd = core_wd_i;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (off_q)
      2'd0:    b = mem_rd_i[7:0];
      2'd1:    b = mem_rd_i[15:8];
      2'd2:    b = mem_rd_i[23:16];
      default: b = mem_rd_i[31:24];
    endcase
    h = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      3'd0:    ext_rd = {{24{b[7]}}, b};
      3'd4:    ext_rd = {24'd0, b};
      3'd1:    ext_rd = {{16{h[15]}}, h};
      3'd5:    ext_rd = {16'd0, h};
      default: ext_rd = mem_rd_i;
    endcase
  end

  assign timeout = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ready beats timeout when both happen in one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (core_req_i) state_d = dec_fault ? RESP : BUSY;
      BUSY: if (mem_ready_i || timeout) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counter, load result and response flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      waddr_q <= 30'd0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      fault_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (core_req_i) begin
            fault_q <= dec_fault;
            berr_q  <= 1'b0;
            if (!dec_fault) begin
              we_q    <= core_we_i;
              size_q  <= core_size_i;
              off_q   <= core_addr_i[1:0];
              waddr_q <= core_addr_i[31:2];
              be_q    <= dec_be;
              wd_q    <= dec_wd;
            end
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            cnt_q <= '0;
            if (!we_q) rd_q <= ext_rd;
          end else if (timeout) begin
            cnt_q  <= '0;
            berr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign core_rd_o    = rd_q;
  assign core_stall_o = core_req_i && (state_q != RESP);
  assign misalign_o   = (state_q == RESP) && fault_q;
  assign bus_err_o    = (state_q == RESP) && berr_q;
  assign mem_req_o    = (state_q == BUSY);
  assign mem_we_o     = we_q;
  assign mem_be_o     = be_q;
  assign mem_addr_o   = {waddr_q, 2'b00};
  assign mem_wd_o     = wd_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed accesses against a small word-addressed
// memory model, with expected responses queued by the driver and checked
// by independent core-side and bus-side monitors.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;

  // response: {stalls[7:0], misalign, bus_err, rd[31:0]}
  logic [41:0] exp_q[$];
  // bus: {req_len[7:0], we, be[3:0], addr[31:0], wd[31:0]}
  logic [76:0] bus_q[$];

  logic [31:0] mem [0:1023];
  int          mem_wait = 0;
  int          mem_busy = 0;
  logic        stray    = 1'b0;

  riscv_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
    .mem_ready_i(mem_ready_i), .dbg_state_o(dbg_state_o)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers after mem_wait BUSY cycles; stray drives ready while idle.
  always @(negedge clk) begin
    if (mem_req_o) begin
      if (mem_busy == mem_wait) begin
        mem_ready_i = 1'b1;
        if (mem_we_o) begin
          for (int i = 0; i < 4; i++)
            if (mem_be_o[i]) mem[mem_addr_o[11:2]][8*i +: 8] = mem_wd_o[8*i +: 8];
          mem_rd_i = 32'd0;
        end else begin
          mem_rd_i = mem[mem_addr_o[11:2]];
        end
      end else begin
        mem_ready_i = 1'b0;
        mem_rd_i    = 32'd0;
      end
      mem_busy++;
    end else begin
      mem_busy    = 0;
      mem_ready_i = stray;
      mem_rd_i    = stray ? 32'h5A5A_5A5A : 32'd0;
    end
  end

  // Core-side monitor: counts stall cycles and checks each response cycle.
  int          stall_n = 0;
  logic [41:0] exp_r;
  always @(negedge clk) begin
    if ((misalign_o || bus_err_o) && !(core_req_i && !core_stall_o)) begin
      errors++;
      $display("FAIL stray_pulse: misalign=%b bus_err=%b outside response", misalign_o, bus_err_o);
    end
    if (rst_i) begin
      stall_n = 0;
    end else if (core_stall_o) begin
      stall_n++;
    end else if (core_req_i) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got a response with empty queue");
      end else begin
        exp_r = exp_q.pop_front();
        check("stall_cycles", 64'(stall_n), 64'(exp_r[41:34]));
        check("misalign", 64'(misalign_o), 64'(exp_r[33]));
        check("bus_err", 64'(bus_err_o), 64'(exp_r[32]));
        check("core_rd", 64'(core_rd_o), 64'(exp_r[31:0]));
      end
      stall_n = 0;
    end
  end

  // Bus-side monitor: checks attributes at request start and length at request end.
  logic        req_prev = 1'b0;
  logic        bus_have = 1'b0;
  int          req_len  = 0;
  logic [76:0] bus_cur;
  always @(negedge clk) begin
    if (mem_req_o && !req_prev) begin
      req_len = 0;
      if (bus_q.size() == 0) begin
        errors++;
        bus_have = 1'b0;
        $display("FAIL bus_unexpected: mem_req_o addr=%h with empty queue", mem_addr_o);
      end else begin
        bus_cur  = bus_q.pop_front();
        bus_have = 1'b1;
        check("mem_we", 64'(mem_we_o), 64'(bus_cur[68]));
        check("mem_be", 64'(mem_be_o), 64'(bus_cur[67:64]));
        check("mem_addr", 64'(mem_addr_o), 64'(bus_cur[63:32]));
        check("mem_wd", 64'(mem_wd_o), 64'(bus_cur[31:0]));
      end
    end
    if (mem_req_o) req_len++;
    if (!mem_req_o && req_prev && bus_have) begin
      check("req_len", 64'(req_len), 64'(bus_cur[76:69]));
      bus_have = 1'b0;
    end
    req_prev = mem_req_o;
  end

  // Drive one access and wait for its response cycle; core_req_i stays high.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int wait_n, input logic [7:0] stalls,
                        input logic mis, input logic berr, input logic [31:0] rd,
                        input logic bus, input logic [7:0] blen, input logic [3:0] be,
                        input logic [31:0] bwd);
    bit done = 0;
    exp_q.push_back({stalls, mis, berr, rd});
    if (bus) bus_q.push_back({blen, we, be, {addr[31:2], 2'b00}, bwd});
    @(posedge clk); #1;
    mem_wait    = wait_n;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (core_req_i && !core_stall_o) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL resp_timeout: no response for addr %h", addr);
    end
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    core_req_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {core_rd_o, core_stall_o, misalign_o, bus_err_o, mem_req_o, mem_we_o,
                 mem_be_o, dbg_state_o}, 64'd0);
    check({name, "_addr_wd"}, {mem_addr_o, mem_wd_o}, 64'd0);
  endtask

  // Stimulus.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[10'h040] = 32'h80AB_CD12;
    mem[10'h080] = 32'hF00D_1234;
    mem[10'h002] = 32'hDEAD_BEEF;
    rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'd0; core_wd_i = 32'd0; mem_ready_i = 1'b0; mem_rd_i = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_state");

    // LB / LBU of the top byte, ready on first BUSY cycle
    access(0, 3'd0, 32'h0000_0103, 32'd0, 0, 8'd2, 0, 0, 32'hFFFF_FF80, 1, 8'd1, 4'b1000, 32'd0);
    drop_req();
    access(0, 3'd4, 32'h0000_0103, 32'd0, 0, 8'd2, 0, 0, 32'h0000_0080, 1, 8'd1, 4'b1000, 32'd0);
    drop_req();
    // SH upper half with 3 wait cycles; rd unchanged
    access(1, 3'd1, 32'h0000_0102, 32'h1234_5678, 3, 8'd5, 0, 0, 32'h0000_0080, 1, 8'd4, 4'b1100, 32'h5678_5678);
    drop_req();
    // LW misaligned: no bus, one stall
    access(0, 3'd2, 32'h0000_0101, 32'd0, 0, 8'd1, 1, 0, 32'h0000_0080, 0, 8'd0, 4'b0000, 32'd0);
    drop_req();
    // LHU / LH of upper half
    access(0, 3'd5, 32'h0000_0202, 32'd0, 1, 8'd3, 0, 0, 32'h0000_F00D, 1, 8'd2, 4'b1100, 32'd0);
    drop_req();
    access(0, 3'd1, 32'h0000_0202, 32'd0, 0, 8'd2, 0, 0, 32'hFFFF_F00D, 1, 8'd1, 4'b1100, 32'd0);
    drop_req();
    // illegal size 3
    access(0, 3'd3, 32'h0000_0200, 32'd0, 0, 8'd1, 1, 0, 32'hFFFF_F00D, 0, 8'd0, 4'b0000, 32'd0);
    drop_req();
    // LW timeout: 16 request cycles, 17 stalls
    access(0, 3'd2, 32'h0000_0400, 32'd0, 1000, 8'd17, 0, 1, 32'hFFFF_F00D, 1, 8'd16, 4'b1111, 32'd0);
    drop_req();

    // reset during the 2nd BUSY cycle of a store
    bus_q.push_back({8'd2, 1'b1, 4'b1111, 32'h0000_0020, 32'hAAAA_AAAA});
    mem_wait = 1000;
    @(posedge clk); #1;
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
    core_addr_i = 32'h0000_0020; core_wd_i = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1; core_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset_state");
    access(0, 3'd2, 32'h0000_0008, 32'd0, 0, 8'd2, 0, 0, 32'hDEAD_BEEF, 1, 8'd1, 4'b1111, 32'd0);
    drop_req();

    // back-to-back stores and loads with ready pulses while idle
    stray = 1'b1;
    access(1, 3'd2, 32'h0000_0010, 32'hCAFE_F00D, 2, 8'd4, 0, 0, 32'hDEAD_BEEF, 1, 8'd3, 4'b1111, 32'hCAFE_F00D);
    access(0, 3'd2, 32'h0000_0010, 32'd0, 1, 8'd3, 0, 0, 32'hCAFE_F00D, 1, 8'd2, 4'b1111, 32'd0);
    access(1, 3'd0, 32'h0000_0011, 32'h0000_00A5, 0, 8'd2, 0, 0, 32'hCAFE_F00D, 1, 8'd1, 4'b0010, 32'hA5A5_A5A5);
    access(0, 3'd2, 32'h0000_0010, 32'd0, 0, 8'd2, 0, 0, 32'hCAFE_A50D, 1, 8'd1, 4'b1111, 32'd0);
    drop_req();
    stray = 1'b0;

    repeat (4) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
